// File: rtl/spike_mac_scan_engine_if.sv
// Serial scan and status signals of spike_mac_scan_engine.
// The engine connects through the slave modport; the driver side uses master.
interface spike_mac_scan_engine_if;
    logic scanIn;
    logic SC_EN;
    logic scanOut;
    logic busy;
    logic done;
    logic sat;
    logic sc_err;

    modport master (
        output scanIn, SC_EN,
        input  scanOut, busy, done, sat, sc_err
    );

    modport slave (
        input  scanIn, SC_EN,
        output scanOut, busy, done, sat, sc_err
    );
endinterface

// File: rtl/spike_mac_scan_engine.sv
// Scan-loaded spiking MAC: serial load of spikes/weights/header, row-serial saturating accumulate, serial readout.
// Optional macro SPIKE_MAC_LEAK_EN adds a leak step before accumulation on passes without CLR.
module spike_mac_scan_engine #(
    parameter int IN_LEN     = 8,
    parameter int OUT_LEN    = 8,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    spike_mac_scan_engine_if.slave sif
);
    localparam int L_IN  = IN_LEN + IN_LEN * OUT_LEN * W_WIDTH + 2;
    localparam int L_OUT = OUT_LEN * ACC_WIDTH;
    localparam int ROW_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(IN_LEN - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LEAK,
        S_ACCUM,
        S_LOAD
    } state_e;

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [L_IN-1:0]      in_sr_q, in_sr_d;
    logic [L_OUT-1:0]     out_sr_q, out_sr_d;
    logic [ACC_WIDTH-1:0] acc_q [OUT_LEN];
    logic [ACC_WIDTH-1:0] acc_d [OUT_LEN];
    logic                 sat_q, sat_d;
    logic                 sc_err_q, sc_err_d;
    logic                 sc_en_q;

    logic                 busy;
    logic                 start;
    logic [IN_LEN-1:0]    spikes;
    logic [W_WIDTH-1:0]   row_w [OUT_LEN];

    // Result is {clamped, sum}; the sum is clamped to the signed accumulator range.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [W_WIDTH-1:0]   w);
        logic [ACC_WIDTH:0] sum;
        sum = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH + 1 - W_WIDTH){w[W_WIDTH-1]}}, w};
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            return {1'b1, (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, sum[ACC_WIDTH-1:0]};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] leak_step(input logic [ACC_WIDTH-1:0] a);
        return a - ($signed(a) >>> LEAK_SHIFT);
    endfunction

    assign busy   = (state_q != S_IDLE);
    assign spikes = in_sr_q[IN_LEN-1:0];
    // A start needs a registered falling edge of SC_EN and a VALID header bit.
    assign start  = sc_en_q && !sif.SC_EN && !busy && in_sr_q[L_IN-1];

    always_comb begin
        for (int j = 0; j < OUT_LEN; j++) begin
            row_w[j] = in_sr_q[IN_LEN + j * W_WIDTH + int'(row_q) * W_WIDTH * OUT_LEN +: W_WIDTH];
        end
    end

    always_comb begin
        logic [ACC_WIDTH:0] add_r;
        // NOTE: every next-state variable takes its hold value first, so no branch can infer a latch.
        state_d  = state_q;
        row_d    = row_q;
        in_sr_d  = in_sr_q;
        out_sr_d = out_sr_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        sc_err_d = sc_err_q;
        add_r    = '0;

        if (sif.SC_EN) begin
            if (busy) begin
                sc_err_d = 1'b1;
            end else begin
                in_sr_d  = {sif.scanIn, in_sr_q[L_IN-1:1]};
                out_sr_d = {1'b0, out_sr_q[L_OUT-1:1]};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (in_sr_q[L_IN-2]) begin
                        state_d = S_CLEAR;
                    end else begin
`ifdef SPIKE_MAC_LEAK_EN
                        state_d = S_LEAK;
`else
                        state_d = S_ACCUM;
`endif
                    end
                end
            end
            S_CLEAR: begin
                for (int j = 0; j < OUT_LEN; j++) begin
                    acc_d[j] = '0;
                end
                sat_d   = 1'b0;
                state_d = S_ACCUM;
            end
            S_LEAK: begin
`ifdef SPIKE_MAC_LEAK_EN
                for (int j = 0; j < OUT_LEN; j++) begin
                    acc_d[j] = leak_step(acc_q[j]);
                end
`endif
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (spikes[row_q]) begin
                    for (int j = 0; j < OUT_LEN; j++) begin
                        add_r    = sat_add(acc_q[j], row_w[j]);
                        acc_d[j] = add_r[ACC_WIDTH-1:0];
                        if (add_r[ACC_WIDTH]) begin
                            sat_d = 1'b1;
                        end
                    end
                end
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            S_LOAD: begin
                for (int j = 0; j < OUT_LEN; j++) begin
                    out_sr_d[j * ACC_WIDTH +: ACC_WIDTH] = acc_q[j];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            in_sr_q  <= '0;
            out_sr_q <= '0;
            sat_q    <= 1'b0;
            sc_err_q <= 1'b0;
            // Held high so a low SC_EN right after reset is not taken as a start edge.
            sc_en_q  <= 1'b1;
            // NOTE: the accumulators are architectural state that RESET must zero, so this array is reset like any flop.
            for (int j = 0; j < OUT_LEN; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
            state_q  <= state_d;
            row_q    <= row_d;
            in_sr_q  <= in_sr_d;
            out_sr_q <= out_sr_d;
            sat_q    <= sat_d;
            sc_err_q <= sc_err_d;
            sc_en_q  <= sif.SC_EN;
            for (int j = 0; j < OUT_LEN; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign sif.scanOut = out_sr_q[0];
    assign sif.busy    = busy;
    assign sif.done    = (state_q == S_LOAD);
    assign sif.sat     = sat_q;
    assign sif.sc_err  = sc_err_q;
endmodule

// File: tb/tb_spike_mac_scan_engine.sv
// Bench for spike_mac_scan_engine: a default build and an ACC_WIDTH=10 build share one stimulus
// and are both checked against an integer model of the pass rules.
module tb_spike_mac_scan_engine;
    localparam int IN_LEN     = 8;
    localparam int OUT_LEN    = 8;
    localparam int W_WIDTH    = 8;
    localparam int ACC_A      = 16;
    localparam int ACC_B      = 10;
    localparam int LEAK_SHIFT = 3;
    localparam int L_IN       = IN_LEN + IN_LEN * OUT_LEN * W_WIDTH + 2;
    localparam int OA         = OUT_LEN * ACC_A;
    localparam int OB         = OUT_LEN * ACC_B;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic scan_in = 1'b0;
    logic sc_en   = 1'b0;

    int errors = 0;
    int checks = 0;

    // Current scan configuration
    int spike [IN_LEN];
    int wgt   [IN_LEN][OUT_LEN];
    int clr_bit;
    int valid_bit;

    // Reference model state
    int acc_a [OUT_LEN];
    int acc_b [OUT_LEN];
    int sat_a, sat_b, err_m;
    logic [OA-1:0] exp_out_a;
    logic [OB-1:0] exp_out_b;
    logic [OA-1:0] cap_a;
    logic [OB-1:0] cap_b;

    always #5 clk = ~clk;

    spike_mac_scan_engine_if if_a ();
    spike_mac_scan_engine_if if_b ();

    assign if_a.scanIn = scan_in;
    assign if_a.SC_EN  = sc_en;
    assign if_b.scanIn = scan_in;
    assign if_b.SC_EN  = sc_en;

    spike_mac_scan_engine #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .W_WIDTH(W_WIDTH),
        .ACC_WIDTH(ACC_A), .LEAK_SHIFT(LEAK_SHIFT)
    ) dut_a (
        .CLK(clk), .RESET(rst), .sif(if_a)
    );

    spike_mac_scan_engine #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .W_WIDTH(W_WIDTH),
        .ACC_WIDTH(ACC_B), .LEAK_SHIFT(LEAK_SHIFT)
    ) dut_b (
        .CLK(clk), .RESET(rst), .sif(if_b)
    );

    function automatic int clamp(input int v, input int width, output int hit);
        int hi;
        int lo;
        hi  = (1 << (width - 1)) - 1;
        lo  = -(1 << (width - 1));
        hit = 0;
        if (v > hi) begin
            hit = 1;
            return hi;
        end
        if (v < lo) begin
            hit = 1;
            return lo;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < OUT_LEN; j++) begin
            acc_a[j] = 0;
            acc_b[j] = 0;
        end
        sat_a = 0;
        sat_b = 0;
        err_m = 0;
        exp_out_a = '0;
        exp_out_b = '0;
    endtask

    // Applies one valid pass to the model; returns start-to-done latency in cycles.
    task automatic model_pass(output int lat);
        int hit;
        if (clr_bit != 0) begin
            for (int j = 0; j < OUT_LEN; j++) begin
                acc_a[j] = 0;
                acc_b[j] = 0;
            end
            sat_a = 0;
            sat_b = 0;
            lat   = IN_LEN + 2;
        end else begin
            lat = IN_LEN + 1;
`ifdef SPIKE_MAC_LEAK_EN
            for (int j = 0; j < OUT_LEN; j++) begin
                acc_a[j] = acc_a[j] - (acc_a[j] >>> LEAK_SHIFT);
                acc_b[j] = acc_b[j] - (acc_b[j] >>> LEAK_SHIFT);
            end
            lat = lat + 1;
`endif
        end
        for (int i = 0; i < IN_LEN; i++) begin
            if (spike[i] != 0) begin
                for (int j = 0; j < OUT_LEN; j++) begin
                    acc_a[j] = clamp(acc_a[j] + wgt[i][j], ACC_A, hit);
                    if (hit != 0) sat_a = 1;
                    acc_b[j] = clamp(acc_b[j] + wgt[i][j], ACC_B, hit);
                    if (hit != 0) sat_b = 1;
                end
            end
        end
        for (int j = 0; j < OUT_LEN; j++) begin
            exp_out_a[j * ACC_A +: ACC_A] = ACC_A'(acc_a[j]);
            exp_out_b[j * ACC_B +: ACC_B] = ACC_B'(acc_b[j]);
        end
    endtask

    task automatic set_cfg_pattern(input int spk_mask, input int w_mode, input int clr);
        for (int i = 0; i < IN_LEN; i++) begin
            spike[i] = (spk_mask >> i) & 1;
            for (int j = 0; j < OUT_LEN; j++) begin
                case (w_mode)
                    0:       wgt[i][j] = i * 16 + j;
                    1:       wgt[i][j] = 127;
                    2:       wgt[i][j] = -128;
                    default: wgt[i][j] = int'($urandom_range(0, 255)) - 128;
                endcase
            end
        end
        clr_bit   = clr;
        valid_bit = 1;
    endtask

    // Shifts the full input chain in while capturing the previous results coming out.
    task automatic load_chain(input string tag);
        logic [L_IN-1:0] ch;
        logic tail_a;
        ch = '0;
        tail_a = 1'b0;
        for (int i = 0; i < IN_LEN; i++) begin
            ch[i] = spike[i][0];
            for (int j = 0; j < OUT_LEN; j++) begin
                ch[IN_LEN + j * W_WIDTH + i * W_WIDTH * OUT_LEN +: W_WIDTH] = W_WIDTH'(wgt[i][j]);
            end
        end
        ch[L_IN-2] = clr_bit[0];
        ch[L_IN-1] = valid_bit[0];
        sc_en = 1'b1;
        for (int k = 0; k < L_IN; k++) begin
            scan_in = ch[k];
            if (k < OA) cap_a[k] = if_a.scanOut;
            if (k < OB) cap_b[k] = if_b.scanOut;
            if (k == OA) tail_a = if_a.scanOut;
            @(posedge clk);
            #1;
        end
        scan_in = 1'b0;
        for (int j = 0; j < OUT_LEN; j++) begin
            checks++;
            if (cap_a[j * ACC_A +: ACC_A] !== exp_out_a[j * ACC_A +: ACC_A]) begin
                errors++;
                $display("FAIL %s out_a[%0d] got %h expected %h", tag, j,
                         cap_a[j * ACC_A +: ACC_A], exp_out_a[j * ACC_A +: ACC_A]);
            end
            checks++;
            if (cap_b[j * ACC_B +: ACC_B] !== exp_out_b[j * ACC_B +: ACC_B]) begin
                errors++;
                $display("FAIL %s out_b[%0d] got %h expected %h", tag, j,
                         cap_b[j * ACC_B +: ACC_B], exp_out_b[j * ACC_B +: ACC_B]);
            end
        end
        checks++;
        if (tail_a !== 1'b0) begin
            errors++;
            $display("FAIL %s zero_fill got %b expected 0", tag, tail_a);
        end
        exp_out_a = '0;
        exp_out_b = '0;
    endtask

    // Starts a pass and waits for done; glitch_at >= 1 raises SC_EN for one cycle mid-pass.
    task automatic run_pass(input string tag, input int glitch_at);
        int lat;
        int cnt;
        logic seen;
        logic busy_bad;
        model_pass(lat);
        if (glitch_at >= 0) err_m = 1;
        cnt      = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && cnt < 40) begin
            sc_en = (cnt == glitch_at);
            @(posedge clk);
            #1;
            cnt++;
            if (if_a.busy !== 1'b1 || if_b.busy !== 1'b1) busy_bad = 1'b1;
            if (glitch_at >= 0 && cnt == glitch_at + 1) begin
                checks++;
                if (if_a.sc_err !== 1'b1 || if_b.sc_err !== 1'b1) begin
                    errors++;
                    $display("FAIL %s sc_err_mid got %b/%b expected 1/1", tag, if_a.sc_err, if_b.sc_err);
                end
            end
            if (if_a.done === 1'b1) seen = 1'b1;
        end
        sc_en = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout got none within %0d cycles expected latency %0d", tag, cnt, lat);
        end else if (cnt != lat) begin
            errors++;
            $display("FAIL %s latency got %0d expected %0d", tag, cnt, lat);
        end
        checks++;
        if (if_b.done !== 1'b1 || busy_bad) begin
            errors++;
            $display("FAIL %s done_b_busy got done_b=%b busy_gap=%b expected 1/0", tag, if_b.done, busy_bad);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({if_a.done, if_a.busy, if_b.done, if_b.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL %s after_done got %b expected 0000", tag,
                     {if_a.done, if_a.busy, if_b.done, if_b.busy});
        end
        checks++;
        if (if_a.sat !== sat_a[0] || if_b.sat !== sat_b[0]) begin
            errors++;
            $display("FAIL %s sat got %b/%b expected %0d/%0d", tag, if_a.sat, if_b.sat, sat_a, sat_b);
        end
        checks++;
        if (if_a.sc_err !== err_m[0] || if_b.sc_err !== err_m[0]) begin
            errors++;
            $display("FAIL %s sc_err got %b/%b expected %0d", tag, if_a.sc_err, if_b.sc_err, err_m);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({if_a.scanOut, if_a.busy, if_a.done, if_a.sat, if_a.sc_err} !== 5'b0) begin
            errors++;
            $display("FAIL %s outputs_a got %b expected 00000", tag,
                     {if_a.scanOut, if_a.busy, if_a.done, if_a.sat, if_a.sc_err});
        end
        checks++;
        if ({if_b.scanOut, if_b.busy, if_b.done, if_b.sat, if_b.sc_err} !== 5'b0) begin
            errors++;
            $display("FAIL %s outputs_b got %b expected 00000", tag,
                     {if_b.scanOut, if_b.busy, if_b.done, if_b.sat, if_b.sc_err});
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        sc_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_directed();
        set_cfg_pattern(8'h80, 0, 1);
        load_chain("dir_load0");
        run_pass("dir_pass_80", -1);
        set_cfg_pattern(8'hFF, 0, 1);
        load_chain("dir_read_80");
        for (int j = 0; j < OUT_LEN; j++) begin
            checks++;
            if (cap_a[j * ACC_A +: ACC_A] !== 16'h70 + 16'(j)) begin
                errors++;
                $display("FAIL dir_const acc[%0d] got %h expected %h", j, cap_a[j * ACC_A +: ACC_A], 16'h70 + 16'(j));
            end
        end
        run_pass("dir_pass_ff_clr", -1);
        set_cfg_pattern(8'hFF, 0, 0);
        load_chain("dir_read_ff");
        run_pass("dir_pass_ff_noclr", -1);
    endtask

    task automatic test_saturation();
        set_cfg_pattern(8'hFF, 1, 1);
        load_chain("sat_read_prev");
`ifndef SPIKE_MAC_LEAK_EN
        for (int j = 0; j < OUT_LEN; j++) begin
            checks++;
            if (cap_a[j * ACC_A +: ACC_A] !== 16'(896 + 16 * j)) begin
                errors++;
                $display("FAIL multipass acc[%0d] got %0d expected %0d", j, cap_a[j * ACC_A +: ACC_A], 896 + 16 * j);
            end
        end
`endif
        run_pass("sat_pass_pos", -1);
        set_cfg_pattern(8'hFF, 2, 1);
        load_chain("sat_read_pos");
        for (int j = 0; j < OUT_LEN; j++) begin
            checks++;
            if (cap_b[j * ACC_B +: ACC_B] !== 10'h1FF || cap_a[j * ACC_A +: ACC_A] !== 16'd1016) begin
                errors++;
                $display("FAIL sat_const acc[%0d] got %h/%h expected 1ff/03f8", j,
                         cap_b[j * ACC_B +: ACC_B], cap_a[j * ACC_A +: ACC_A]);
            end
        end
        run_pass("sat_pass_neg", -1);
    endtask

    task automatic test_valid_low();
        logic bad;
        sc_en   = 1'b1;
        scan_in = 1'b0;
        @(posedge clk);
        #1;
        exp_out_a = exp_out_a >> 1;
        exp_out_b = exp_out_b >> 1;
        sc_en = 1'b0;
        bad   = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if ({if_a.busy, if_a.done, if_b.busy, if_b.done} !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL valid_low got busy/done activity expected none");
        end
    endtask

    task automatic test_sc_err();
        set_cfg_pattern(int'($urandom_range(0, 255)), 3, 0);
        load_chain("scerr_read");
        run_pass("scerr_pass", 2);
        set_cfg_pattern(int'($urandom_range(0, 255)), 3, 1);
        load_chain("scerr_result");
        run_pass("scerr_next", -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            set_cfg_pattern(int'($urandom_range(0, 255)), 3, int'($urandom_range(0, 1)));
            load_chain($sformatf("rand_read%0d", n));
            run_pass($sformatf("rand_pass%0d", n), -1);
        end
    endtask

    task automatic test_reset_mid_pass();
        set_cfg_pattern(8'hFF, 1, 0);
        load_chain("rst_read");
        sc_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (if_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy got %b expected 1", if_a.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset_mid");
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("reset_after");
        set_cfg_pattern(int'($urandom_range(0, 255)), 3, 0);
        load_chain("rst_zeros");
        run_pass("rst_pass", -1);
        set_cfg_pattern(8'h00, 3, 0);
        load_chain("rst_pass_read");
    endtask

`ifdef SPIKE_MAC_LEAK_EN
    task automatic test_leak();
        set_cfg_pattern(8'hFF, 0, 1);
        load_chain("leak_read0");
        run_pass("leak_fill", -1);
        set_cfg_pattern(8'h00, 0, 0);
        load_chain("leak_read448");
        run_pass("leak_pass", -1);
        load_chain("leak_read392");
        checks++;
        if (cap_a[ACC_A-1:0] !== 16'd392) begin
            errors++;
            $display("FAIL leak_const acc[0] got %0d expected 392", cap_a[ACC_A-1:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_valid_low();
        test_sc_err();
        test_random();
        test_reset_mid_pass();
`ifdef SPIKE_MAC_LEAK_EN
        test_leak();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spike_mac_scan_engine.md
Name: spike_mac_scan_engine

Overview:
- Scan-loaded spiking MAC for the DPE. A single serial chain loads a binary spike vector, a signed weight matrix and a control header.
- When SC_EN is deasserted, the block time-multiplexes the multiply-accumulate over the inputs, one input row per cycle, into persistent saturating per-output accumulators.
- Results are shifted back out on scanOut.
- Successor to the fixed-size spike MAC wrapper. Adds parametrised dimensions, multi-pass accumulation, clear control, saturation and status flags.

Parameters:
- IN_LEN, 8, spike vector length (matrix rows).
- OUT_LEN, 8, output count (matrix columns).
- W_WIDTH, 8, signed two's-complement weight width.
- ACC_WIDTH, 16, signed accumulator / output width; must be >= W_WIDTH+1.
- LEAK_SHIFT, 3, leak divisor exponent; used only with SPIKE_MAC_LEAK_EN.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- scanIn  in  1  serial data into the input chain.
- SC_EN  in  1  1 = shift; 1->0 transition = start a pass.
- scanOut  out  1  serial result, equal to out_sr[0].
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when results are loaded.
- sat  out  1  sticky: some accumulator saturated.
- sc_err  out  1  sticky: SC_EN asserted while busy.

Behaviour:
- Input chain length L_IN = IN_LEN + IN_LEN*OUT_LEN*W_WIDTH + 2.
  - Shift: scanIn enters at bit L_IN-1 and bits move toward bit 0. The first bit shifted in ends at bit 0 after L_IN shifts.
  - Layout: [IN_LEN-1:0] = spike[i].
  - Weight w[i][j] = bits IN_LEN + j*W_WIDTH + i*W_WIDTH*OUT_LEN +: W_WIDTH.
  - Bit L_IN-2 = CLR. Bit L_IN-1 = VALID.
- Output chain is OUT_LEN*ACC_WIDTH bits. acc[j] occupies j*ACC_WIDTH +: ACC_WIDTH. Shifted out LSB first, output 0 first; zero fill at top.
- The cycle SC_EN=1 and busy=0 shifts both chains by one bit. When busy=1, both chains hold, scanIn is ignored, and SC_EN=1 sets sc_err.
- Start: SC_EN registered, then falling edge detected (SC_EN_q=1, SC_EN=0). If VALID=0, ignore the start: no state change, no done.
- FSM states:
  - IDLE -> CLEAR if CLR=1, else -> ACCUM.
  - CLEAR: all acc <= 0, sat <= 0 (1 cycle) -> ACCUM.
  - ACCUM: row counter i from 0 to IN_LEN-1, one row per cycle. For every j in parallel, if spike[i]=1 then acc[j] <= sat_add(acc[j], sign_ext(w[i][j])). Rows with spike[i]=0 still take one cycle. Exits after i = IN_LEN-1 -> LOAD.
  - LOAD: out_sr <= {acc}; done = 1 for this cycle -> IDLE.
- sat_add clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets sat.
- Latency, start detection to done: IN_LEN+1 cycles (CLR=0) or IN_LEN+2 cycles (CLR=1). busy is high from the first FSM cycle after IDLE through LOAD inclusive.
- Accumulators persist across passes. Only CLR or RESET zeroes them.
- Input chain contents are not consumed: a new start with an unchanged chain repeats the same pass.
- RESET, any time including mid-pass: FSM to IDLE, row counter 0, input chain 0, out_sr 0, acc 0, SC_EN_q 1 (so no spurious start). All outputs 0: scanOut, busy, done, sat, sc_err.
- A start edge while busy cannot occur, because SC_EN must have risen, which is already flagged by sc_err. The pass completes normally.

Optional Feature:
- Macro SPIKE_MAC_LEAK_EN.
- Defined: a pass with CLR=0 inserts a LEAK state before ACCUM. In LEAK, acc[j] <= acc[j] - (acc[j] >>> LEAK_SHIFT), arithmetic shift, no saturation possible. The extra cycle makes latency IN_LEN+2.
- Undefined: no LEAK state and LEAK_SHIFT unused. CLR=1 passes are identical either way.

Test Plan:
- Defaults. Weights w[i][j] = {i[3:0], j[3:0]}, spikes 0x80, CLR=1, VALID=1. Shift L_IN bits, drop SC_EN 2 cycles, then shift 128 bits out -> acc[j] = 0x70+j. done arrives 10 cycles after start, sat=0.
- Same weights, spikes 0xFF, CLR=1 -> acc[j] = 448+8j. Repeat start with the chain unchanged but CLR=0 -> acc[j] = 896+16j (leak undefined).
- ACC_WIDTH=10, all weights 0x7F, spikes 0xFF, CLR=1 -> every acc = 511, sat=1. Next pass with weights 0x80, CLR=1 -> every acc = -512, sat=1.
- VALID=0 with SC_EN falling -> busy and done stay 0, and previous results shift out unchanged.
- SC_EN raised 2 cycles into a pass -> sc_err=1, chains hold, and the pass still yields correct results.
- Assert RESET mid-ACCUM -> all outputs 0 on the next cycle, and scanOut shifts zeros. With SPIKE_MAC_LEAK_EN: acc=448 followed by a CLR=0 pass with spikes 0x00 -> 392.
